// File: rtl/address_calculator.sv
`default_nettype none
// =============================================================================
// address_calculator - ZBT word address, song_done and per-song length table
// Rev 1.0
// =============================================================================
module address_calculator #(
    parameter int ADDR_W = 19,
    parameter int OFS_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              start_song,
    input  logic [3:0]        song_choice,
    input  logic              record_mode,
    input  logic              pause_song,
    output logic [ADDR_W-1:0] addr,
    output logic              song_done,
    output logic [OFS_W:0]    cur_length,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REC  = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0]       PH_LAST = 2'd2;
    localparam logic [OFS_W-1:0] OFS_MAX = '1;
    localparam logic [OFS_W:0]   LEN_ONE = {{OFS_W{1'b0}}, 1'b1};

    logic [1:0]       cur_state, nxt_state;
    logic [3:0]       song, nxt_song;
    logic             rec, nxt_rec;
    logic [1:0]       phase, nxt_phase;
    logic [OFS_W-1:0] word_offset, nxt_offset;
    logic [OFS_W:0]   length [16];

    logic             len_we;
    logic [OFS_W:0]   len_val;
    logic [OFS_W:0]   ofs_inc;
    logic             advance;

    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_done;
    logic [OFS_W:0]    nxt_cur_length;

    assign state   = cur_state;
    assign ofs_inc = {1'b0, word_offset} + LEN_ONE;
    assign advance = ready && !pause_song && (cur_state == S_REC || cur_state == S_PLAY);

    // State register, datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= S_IDLE;
            song        <= '0;
            rec         <= 1'b0;
            phase       <= '0;
            word_offset <= '0;
            addr        <= '0;
            song_done   <= 1'b1;
            cur_length  <= '0;
            for (int i = 0; i < 16; i++) begin
                length[i] <= '0;
            end
        end else begin
            cur_state   <= nxt_state;
            song        <= nxt_song;
            rec         <= nxt_rec;
            phase       <= nxt_phase;
            word_offset <= nxt_offset;
            addr        <= nxt_addr;
            song_done   <= nxt_done;
            cur_length  <= nxt_cur_length;
            if (len_we) begin
                length[nxt_song] <= len_val;
            end
        end
    end

    // start_song outranks any ready arriving in the same cycle
    always_comb begin
        nxt_state  = cur_state;
        nxt_song   = song;
        nxt_rec    = rec;
        nxt_phase  = phase;
        nxt_offset = word_offset;
        len_we     = 1'b0;
        len_val    = '0;
        if (start_song) begin
            nxt_song   = song_choice;
            nxt_rec    = record_mode;
            nxt_phase  = '0;
            nxt_offset = '0;
            if (record_mode) begin
                len_we    = 1'b1;
                nxt_state = S_REC;
            end else if (length[song_choice] == '0) begin
                nxt_state = S_DONE;
            end else begin
                nxt_state = S_PLAY;
            end
        end else if (advance) begin
            if (phase != PH_LAST) begin
                nxt_phase = phase + 2'd1;
            end else begin
                nxt_phase = '0;
                if (rec) begin
                    len_we  = 1'b1;
                    len_val = ofs_inc;
                    if (word_offset == OFS_MAX) begin
                        nxt_state = S_DONE;
                    end else begin
                        nxt_offset = word_offset + 1'b1;
                    end
                end else begin
                    nxt_offset = word_offset + 1'b1;
                    if (ofs_inc == length[song]) begin
                        nxt_state = S_DONE;
                    end
                end
            end
        end
    end

    // Length bypass keeps cur_length aligned with the table write on the same edge
    always_comb begin
        nxt_addr       = ADDR_W'({nxt_song[2:0], nxt_offset});
        nxt_done       = (nxt_state == S_IDLE) || (nxt_state == S_DONE);
        nxt_cur_length = len_we ? len_val : length[nxt_song];
    end

endmodule
`default_nettype wire

// File: doc/address_calculator.md
# address_calculator

Generates the ZBT word address and the `song_done` flag for the audio record/playback path. It tracks the same three-samples-per-word cadence as the memory processor and maps each of 16 songs onto a fixed region of one of the two ZBT banks. It also keeps a per-song recorded-length table, so playback stops exactly where recording ended. It sits beside the memory processor: both take `ready` and the FSM song controls, and this block drives the shared ZBT address bus and the memory processor's `song_done` input.

## Interface
- `ADDR_W`, 19: ZBT word-address width. 512K words per bank.
- `OFS_W`, 16: in-region word-offset width. 65536 words per song.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high. Clears all state, including the length table.
- `ready` in 1: one-cycle pulse per AC97 sample.
- `start_song` in 1: one-cycle pulse from the FSM. Starts a record or playback pass.
- `song_choice` in 4: song index. Bit 3 selects the bank (the memory processor decodes this); bits [2:0] select the region.
- `record_mode` in 1: 1 = record, 0 = playback. Sampled only on `start_song`.
- `pause_song` in 1: while high, `ready` is ignored and all state holds.
- `addr` out ADDR_W: `{region[2:0], word_offset[15:0]}`. Driven to both ZBT banks.
- `song_done` out 1: high when no pass is active (idle, finished, or full).
- `cur_length` out 17: recorded length of the latched song, in words (0..65536).
- `state` out 2: 0 IDLE, 1 RECORD, 2 PLAY, 3 DONE. For debug/LEDs.

## Operation
- Registers:
  - `state`
  - latched `song` (4 bits) and `rec` (1 bit)
  - `phase` (0..2)
  - `word_offset` (16 bits)
  - `length[0..15]` (17 bits each)
- Reset values: state=IDLE, song=0, rec=0, phase=0, word_offset=0, all lengths=0, addr=0, song_done=1, cur_length=0.
- `start_song` (any state, highest priority, overrides `ready` and `pause_song` in the same cycle):
  - Latch `song_choice` and `record_mode`; set phase=0 and word_offset=0.
  - If record: set length[song_choice]=0, go to RECORD, song_done=0.
  - If playback with length[song_choice]=0: go to DONE, song_done=1.
  - Otherwise: go to PLAY, song_done=0.
- Advance event: `ready` high, `pause_song` low, state is RECORD or PLAY.
  - Phase 0 or 1: phase increments.
  - Phase 2: phase wraps to 0 and a word boundary is processed as described below.
- RECORD word boundary:
  - length[song] <= word_offset+1.
  - If word_offset == 0xFFFF: word_offset holds, state=DONE, song_done=1. Length ends at 65536.
  - Otherwise: word_offset increments.
- PLAY word boundary:
  - word_offset increments.
  - If word_offset+1 == length[song]: state=DONE, song_done=1.
  - `addr` may then point one past the recorded data; the memory processor ignores it because `song_done` is high.
- IDLE and DONE: `ready` and `pause_song` have no effect. Only `start_song` leaves these states.
- Outputs:
  - `cur_length` = length[song], registered.
  - `addr` = {song[2:0], word_offset}, registered.
- `song_choice` and `record_mode` changes outside a `start_song` pulse are ignored.

## Timing
- All outputs are registered. Every update lands on the edge that samples the triggering input, so outputs are visible one cycle after the pulse is presented.
- `addr` changes only on the edge of a phase-2 advance or a `start_song`. It is otherwise stable for the roughly 1000+ cycles between `ready` pulses, which covers ZBT pipeline latency.
- `phase` stays in lockstep with the memory processor's mod-3 sample counter. Both reset to 0 on `start_song`, and both advance on the same qualified `ready`.
- `song_done` rises on the same edge as the final word boundary. The next qualified `ready` is already blocked.
- Async `reset` mid-pass: state aborts immediately and recorded lengths are lost. `addr` and `song_done` take their reset values without waiting for a clock.
- `ready` and `start_song` in the same cycle: `start_song` wins, and that `ready` is not counted.

## Test plan
- After reset: addr=0, song_done=1, state=0. Apply 10 `ready` pulses. Expect addr still 0 and song_done still 1.
- `start_song` with record_mode=1, song_choice=4'b1011, then 9 `ready` pulses. Expect addr = 19'h30003, cur_length=3, song_done=0.
- Continue from the previous case: `start_song` with playback, same song, then 9 `ready` pulses. After the 9th, expect song_done=1, state=3, and addr 19'h30003. Additional `ready` pulses leave addr unchanged.
- Recording with `pause_song` high for 5 `ready` pulses, then low for 3. Expect exactly one word advance. Then pulse `start_song` together with `ready`: expect phase=0 and word_offset=0.
- Record song 0 until full (196608 `ready` pulses). Expect song_done=1, addr=19'h0FFFF, cur_length=65536.
- Playback of a never-recorded song (song 5): expect song_done=1 and state=3 one cycle after `start_song`. Assert `reset` mid-record: expect all outputs to reach reset values with no clock edge.
